// File: rtl/i2c_pkg.sv
// Shared I2C constants: FSM encodings for master and target, ACK levels,
// address width.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Master-side state encoding (used by the companion master block).
  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_START = 3'd1;
  localparam logic [2:0] M_ADDR  = 3'd2;
  localparam logic [2:0] M_DATA  = 3'd3;
  localparam logic [2:0] M_ACK   = 3'd4;
  localparam logic [2:0] M_STOP  = 3'd5;

  // Target-side state encoding, visible on the debug state port.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_WRITE_ACK = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_ACK  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
// Synchroniser and history flops reset to 1 (idle bus level).
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Synchroniser chains plus one history flop per line.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // SCL must be high in both samples so an SDA edge coincident with an
  // SCL edge is not mistaken for a bus condition.
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C target: 7-bit address match, write bytes out on rx_valid, read bytes
// fetched via tx_req and shifted out open-drain. Never stretches SCL.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic [2:0] state
);

  logic       unused_scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_oe;
  logic       rw;
  logic       ack_seen;
  logic [2:0] cnt;
  logic [2:0] cnt_m1;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic       load_tx;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_s     (unused_scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain drive: pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign shift_nxt = {shift[6:0], sda_s};
  assign cnt_m1    = cnt - 3'd1;

  // A read byte is fetched on the SCL fall that closes an ACK slot: the
  // address ACK of a read, or a master ACK in READ_ACK. tx_req is high in
  // exactly the cycle whose clock edge captures tx_data.
  assign load_tx = scl_fall && !start_det && !stop_det &&
                   (((state == S_ADDR_ACK) && sda_oe && rw) ||
                    ((state == S_READ_ACK) && ack_seen));
  assign tx_req  = !rst && load_tx;

  // Target FSM; STOP and START outrank SCL edges in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 3'd7;
      shift    <= 8'h00;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rw       <= 1'b0;
      ack_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (stop_det) begin
        state    <= S_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        cnt      <= 3'd7;
        ack_seen <= 1'b0;
      end else if (start_det) begin
        state    <= S_ADDR;
        sda_oe   <= 1'b0;
        cnt      <= 3'd7;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift <= shift_nxt;
              if (cnt == 3'd0) begin
                rw <= sda_s;
                if (shift_nxt[7:1] == SLAVE_ADDR) begin
                  state <= S_ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= S_WAIT_STOP;
                end
              end else begin
                cnt <= cnt_m1;
              end
            end
          end
          S_ADDR_ACK: begin
            // First fall starts the ACK slot, second fall ends it.
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
                cnt    <= 3'd7;
                state  <= S_READ;
              end else begin
                sda_oe <= 1'b0;
                cnt    <= 3'd7;
                state  <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            if (scl_rise) begin
              shift <= shift_nxt;
              if (cnt == 3'd0) begin
                rx_data  <= shift_nxt;
                rx_valid <= 1'b1;
                state    <= S_WRITE_ACK;
              end else begin
                cnt <= cnt_m1;
              end
            end
          end
          S_WRITE_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                cnt    <= 3'd7;
                state  <= S_WRITE;
              end
            end
          end
          S_READ: begin
            // cnt indexes the bit currently on the bus.
            if (scl_fall) begin
              if (cnt == 3'd0) begin
                sda_oe <= 1'b0;
                cnt    <= 3'd7;
                state  <= S_READ_ACK;
              end else begin
                sda_oe <= ~shift[cnt_m1];
                cnt    <= cnt_m1;
              end
            end
          end
          S_READ_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                state <= S_WAIT_STOP;
              end else begin
                ack_seen <= 1'b1;
              end
            end else if (load_tx) begin
              shift    <= tx_data;
              sda_oe   <= ~tx_data[7];
              cnt      <= 3'd7;
              ack_seen <= 1'b0;
              state    <= S_READ;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged master, table of write transactions,
// hand-written read / repeated-start / abort / reset sequences.
module tb_i2c_slave_rx;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_sda_low;
  wire        sda;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic [2:0] state;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .busy     (busy),
    .state    (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_fail;
  int         rx_cnt;
  int         tx_cnt;
  logic       oe_seen;
  logic       tx_adv;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       match;
  } wvec_t;

  wvec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk step; all DUT observation happens here, away from posedge.
  task automatic tick();
    @(negedge clk);
    if (tx_adv) begin
      tx_adv  = 1'b0;
      tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hxx);
      else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (tx_req) begin
      tx_cnt++;
      check("tx_req_excl_rx_valid", 32'(rx_valid), 32'd0);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      tx_adv = 1'b1;
    end
    if (sda === 1'b0 && !m_sda_low) oe_seen = 1'b1;
  endtask

  task automatic quarter();
    repeat (Q) tick();
  endtask

  task automatic set_tx(input logic [7:0] b);
    tx_q.push_back(b);
    if (tx_q.size() == 1) tx_data = b;
  endtask

  // START from idle (SCL high) or repeated START (SCL low).
  task automatic i2c_start();
    m_sda_low = 1'b0; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b1; quarter();
    scl = 1'b0;       quarter();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b0; quarter();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; quarter();
    scl = 1'b1;     quarter(); quarter();
    scl = 1'b0;     quarter();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; quarter();
    scl = 1'b1;       quarter();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    quarter();
    scl = 1'b0;       quarter();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         rx0;
    int         tx0;

    n_cmp = 0; n_fail = 0; rx_cnt = 0; tx_cnt = 0;
    oe_seen = 1'b0; tx_adv = 1'b0;
    rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1};
    vecs[1] = '{8'hA2, 8'h55, 1'b0};
    vecs[2] = '{8'hA0, 8'h00, 1'b1};
    vecs[3] = '{8'hA0, 8'hFF, 1'b1};
    vecs[4] = '{8'h20, 8'hA5, 1'b0};
    vecs[5] = '{8'hA0, 8'(($urandom_range(0, 255))), 1'b1};

    // reset
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_tx_req", 32'(tx_req), 32'd0);
    check("reset_sda", 32'(sda === 1'b1), 32'd1);

    // table of single-byte writes
    foreach (vecs[i]) begin
      rx0 = rx_cnt;
      oe_seen = 1'b0;
      if (vecs[i].match) exp_q.push_back(vecs[i].data);
      i2c_start();
      write_byte(vecs[i].addr_byte, ack);
      check("addr_ack", 32'(ack), vecs[i].match ? 32'd0 : 32'd1);
      check("busy_after_addr", 32'(busy), 32'(vecs[i].match));
      write_byte(vecs[i].data, ack);
      check("data_ack", 32'(ack), vecs[i].match ? 32'd0 : 32'd1);
      i2c_stop();
      quarter();
      check("wr_state_idle", 32'(state), 32'd0);
      check("wr_busy_clear", 32'(busy), 32'd0);
      check("wr_sda_pulled", 32'(oe_seen), 32'(vecs[i].match));
      check("wr_rx_count", 32'(rx_cnt - rx0), 32'(vecs[i].match));
    end

    // read two bytes: ACK then NACK
    tx0 = tx_cnt;
    set_tx(8'h96);
    set_tx(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(rb, 1'b0);
    check("rd_byte0", 32'(rb), 32'h96);
    read_byte(rb, 1'b1);
    check("rd_byte1", 32'(rb), 32'h5A);
    quarter();
    check("rd_wait_stop", 32'(state), 32'd7);
    check("rd_busy", 32'(busy), 32'd1);
    i2c_stop();
    quarter();
    check("rd_tx_req_count", 32'(tx_cnt - tx0), 32'd2);
    check("rd_state_idle", 32'(state), 32'd0);

    // repeated start: write 0x01 then read one byte
    rx0 = rx_cnt; tx0 = tx_cnt;
    exp_q.push_back(8'h01);
    set_tx(8'hC3);
    i2c_start();
    write_byte(8'hA0, ack);
    check("rs_addr_w_ack", 32'(ack), 32'd0);
    write_byte(8'h01, ack);
    check("rs_data_ack", 32'(ack), 32'd0);
    i2c_start();
    check("rs_busy_kept", 32'(busy), 32'd1);
    write_byte(8'hA1, ack);
    check("rs_addr_r_ack", 32'(ack), 32'd0);
    read_byte(rb, 1'b1);
    check("rs_read_byte", 32'(rb), 32'hC3);
    i2c_stop();
    quarter();
    check("rs_rx_data", 32'(rx_data), 32'h01);
    check("rs_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("rs_tx_count", 32'(tx_cnt - tx0), 32'd1);
    check("rs_state_idle", 32'(state), 32'd0);

    // STOP in the middle of a data byte
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("ab_addr_ack", 32'(ack), 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    quarter();
    check("ab_rx_count", 32'(rx_cnt - rx0), 32'd0);
    check("ab_state_idle", 32'(state), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_sda_released", 32'(sda === 1'b1), 32'd1);

    // reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(rb[i] & 1'b0 | (8'hA0 >> i) & 1'b1);
    m_sda_low = 1'b0;
    tick();
    check("rst_ack_driven", 32'(sda === 1'b0), 32'd1);
    check("rst_ack_state", 32'(state), 32'd2);
    rst = 1'b1;
    tick();
    check("rst_sda_released", 32'(sda === 1'b1), 32'd1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    rst = 1'b0;
    scl = 1'b1;
    quarter();
    check("rst_stays_idle", 32'(state), 32'd0);

    // recovery after reset
    exp_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA0, ack);
    check("rec_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h5A, ack);
    check("rec_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    quarter();
    check("rec_rx_data", 32'(rx_data), 32'h5A);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C target (slave) block that sits directly downstream of the team's I2C master on the shared SCL/SDA bus. It consumes the START / address / R/W / data / STOP sequences that the master produces.
- SCL and SDA are oversampled in the system clock domain, then passed through a synchroniser and an edge detector.
- The block matches a 7-bit address and ACKs it. Write bytes are delivered on a valid strobe; read bytes are requested from user logic and shifted out open-drain.
- Serves as the on-chip loopback target and as the FPGA-side register endpoint.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target answers to.
- SYNC_STAGES, 2, flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  synchronous active-high reset.
- scl  in  1  I2C clock from the bus (target never stretches).
- sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else 'bz.
- tx_data  in  8  byte to return on a read; sampled when tx_req pulses.
- rx_data  out  8  last received write byte.
- rx_valid  out  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_req  out  1  one-cycle strobe; tx_data is captured in the same cycle.
- busy  out  1  high from an addressed START until STOP.
- state  out  3  current FSM state, for debug.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, on port rst. All registers update only on posedge clk.
- Reset values: rx_data=0, rx_valid=0, tx_req=0, busy=0, sda_oe=0 (bus released), state=IDLE, bit counter=7, shift register=0, synchronisers=1.
- Input conditioning: scl and sda pass through SYNC_STAGES flops plus one history flop.
  - scl_rise / scl_fall are one-cycle pulses.
  - START = sda_s falls while scl_s is high. STOP = sda_s rises while scl_s is high.
- Sampling and drive edges: SDA is sampled only on scl_rise. sda_oe changes only on the cycle after scl_fall, so SDA is never changed while SCL is high.
- States (3-bit encoding): IDLE=0, ADDR=1, ADDR_ACK=2, WRITE=3, WRITE_ACK=4, READ=5, READ_ACK=6, WAIT_STOP=7.
- IDLE: START -> ADDR, counter=7.
- ADDR: shift sda_s MSB-first on each scl_rise. After the 8th bit (counter==0):
  - address bits [7:1]==SLAVE_ADDR -> ADDR_ACK, and busy=1.
  - otherwise -> WAIT_STOP (no ACK).
- ADDR_ACK: assert sda_oe from the scl_fall after bit 8 through the scl_fall after the ACK clock.
  - If R/W=1: tx_req pulses on the scl_fall that ends ACK; tx_data is loaded into the shift register; then READ.
  - If R/W=0: then WRITE.
  - counter=7 on exit.
- WRITE: shift 8 bits. On the 8th scl_rise, rx_data=shifted byte and rx_valid=1 on the next cycle (latency 1 clk). -> WRITE_ACK.
- WRITE_ACK: drive ACK (sda_oe=1) for one SCL period, release on the closing scl_fall. -> WRITE for the next byte, unbounded byte count.
- READ: on each scl_fall, sda_oe = ~shift[counter], giving MSB first. Release after the 8th bit's scl_fall. -> READ_ACK.
- READ_ACK: sample master ACK on scl_rise.
  - 0 (ACK) -> tx_req pulse at the next scl_fall, load tx_data, -> READ.
  - 1 (NACK) -> WAIT_STOP, bus released.
- WAIT_STOP: sda_oe=0; wait for STOP or START.
- Priority: STOP in any state -> IDLE, sda_oe=0, busy=0, counter=7. START in any state (repeated start) -> ADDR, sda_oe=0, busy unchanged. START/STOP outrank scl edges in the same cycle.
- Simultaneous scl_rise and scl_fall cannot occur. A START while sda_oe=1 is not detectable, so sda_oe is dropped on STOP/START by the rule above.
- rx_valid and tx_req are never high in the same cycle. Each is high for exactly 1 clk per byte.
- Reset mid-transfer: bus released within the reset cycle, all outputs at reset values, next START required.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding localparams (IDLE..STOP of the master, and the target states above);
  - the I2C_ACK=0 / I2C_NACK=1 constants;
  - the 7-bit address width constant.
- One natural sub-module, i2c_bus_sync: the SYNC_STAGES synchroniser plus edge/START/STOP detector. Outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det. It is reusable by a future master-side arbitration monitor.

Test Plan:
- Write, addr match: START, 0xA0, data 0x3C, STOP -> ACK on address and data bits, rx_valid once with rx_data=0x3C, busy 1->0 at STOP.
- Address mismatch: START, 0xA2, 0x55, STOP -> SDA never pulled low, rx_valid never asserted, busy stays 0, state returns IDLE.
- Read two bytes: START, 0xA1; tx_data=0x96 then 0x5A; master ACK then NACK; STOP -> SDA bits 10010110 then 01011010, tx_req pulses twice, FSM in WAIT_STOP after NACK.
- Repeated start: START, 0xA0, 0x01, START, 0xA1, read 1 byte with NACK, STOP -> rx_data=0x01, then read path taken, no STOP required between.
- STOP mid-byte: START, 0xA0, 4 data bits, STOP -> no rx_valid, state IDLE, sda_oe=0.
- Reset mid-ACK: assert rst for 1 clk while sda_oe=1 in ADDR_ACK -> SDA released the next cycle, all outputs at reset values.
